framebuffer_blitter: RTL
========================

# framebuffer_blitter

Rectangle-copy engine that sequences pixel transfers from a sprite source memory (gym map or character sheet) into the 240x160 framebuffer RAM, one pixel per clock. It accepts one copy command at a time over a valid/ready handshake. It drives the source read address, absorbs the one-cycle registered read latency, and issues framebuffer writes. Writes are skipped for the transparency key colour and for pixels that fall off-screen. It sits between the game-state logic that requests draws and the RAM instances.

## Interface
Parameters:
- FB_W, 240, framebuffer width in pixels
- FB_H, 160, framebuffer height in pixels
- KEY, 24'hFF00FF, transparency key colour

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  blitter can accept a command; reset 1.
- cmd_src_sel  in  1  source select: 0 = map, 1 = character sheet; latched at accept.
- cmd_src_base  in  19  source address of the top-left pixel.
- cmd_src_stride  in  10  source row pitch in pixels.
- cmd_w  in  8  width in pixels; 0 = empty.
- cmd_h  in  8  height in pixels; 0 = empty.
- cmd_dst_x  in  10  signed destination x.
- cmd_dst_y  in  10  signed destination y.
- cmd_key_en  in  1  enable transparency skipping.
- src_sel  out  1  latched source select, steering the read mux; reset 0.
- src_addr  out  19  source read address; reset 0.
- src_data  in  24  source RAM data_Out; valid 1 cycle after src_addr.
- fb_we  out  1  framebuffer write enable; reset 0.
- fb_addr  out  19  framebuffer write address, computed as y*FB_W + x; reset 0.
- fb_data  out  24  write data; reset 0.
- busy  out  1  command in progress; reset 0.
- done  out  1  one-cycle pulse when the final write slot retires; reset 0.

## Operation
- States are IDLE, RUN, DRAIN and FIN. cmd_ready is 1 only in IDLE.
- IDLE:
  - A command is accepted when cmd_valid and cmd_ready are both 1. All cmd_* fields are latched, and col and row are cleared.
  - If cmd_w==0 or cmd_h==0, go to FIN with no writes. Otherwise go to RUN.
- RUN, each cycle:
  - src_addr = row_base + col, where row_base starts at cmd_src_base and advances by cmd_src_stride per row. Compute it incrementally, with no multiplier on the source side.
  - Push (dst_x+col, dst_y+row, in_bounds) into a 1-deep pipeline register.
  - Advance col. At col==w-1, wrap col to 0 and increment row. At the last pixel (col==w-1, row==h-1), go to DRAIN.
- Write stage (one cycle after issue):
  - fb_we = pipe_valid & in_bounds & ~(key_en & src_data==KEY).
  - fb_data = src_data.
- DRAIN: retires the last pipelined pixel, then goes to FIN.
- FIN: pulses done for one cycle, then returns to IDLE.
- Clipping: in_bounds requires 0<=x<FB_W and 0<=y<FB_H, using signed 11-bit compares. Source reads still occur for clipped pixels, which keeps timing fixed.
- Address arithmetic:
  - src_addr wraps modulo 2^19.
  - fb_addr = y*240 + x. For in-bounds pixels it is at most 38399.
  - fb_addr is computed by shift-add: (y<<8) - (y<<4) + x.
- Reset_n low at any time, including mid-RUN: state goes to IDLE, the pipeline valid bit clears, and fb_we=0 and done=0 asynchronously. No partial command resumes.
- cmd_* changes while busy are ignored.

## Timing
- Accept at edge N. First src_addr is presented in cycle N+1. First possible fb_we is in cycle N+2.
- Throughput is 1 pixel per cycle, with no bubbles across row wrap.
- A w×h command occupies w*h RUN cycles, plus 1 DRAIN cycle, plus 1 FIN cycle.
  - done asserts w*h+2 cycles after the accept edge.
  - cmd_ready returns 1 the cycle after done.
- An empty command pulses done 1 cycle after accept.
- src_data is sampled in the cycle after the matching src_addr. This matches the 1-cycle registered read of both source RAMs; the map palette decode sits inside that latency.

## Structure
- Shared package `blit_pkg` holds:
  - FB_W, FB_H and KEY constants
  - the `blit_state_t` enum (IDLE, RUN, DRAIN, FIN)
  - the `blit_cmd_t` packed struct of all cmd_* fields
- One natural sub-module, `blit_addr_gen`. It owns col, row, row_base, the src_addr computation, and the dst x/y and in_bounds generation. The top level keeps the FSM, the pipeline register and the write-enable logic.

## Test plan
- Opaque copy:
  - Stimulus: 16×16 from char base 0, stride 16, dst (10,20), key_en=0.
  - Required: 256 writes; first write fb_addr=4810, last fb_addr=8425; done at accept+258.
- Transparency:
  - Stimulus: 4×1 source row {000000, FF00FF, 101010, FF00FF}, key_en=1.
  - Required: exactly 2 writes, at x offsets 0 and 2.
  - Stimulus: the same command with key_en=0.
  - Required: 4 writes.
- Clipping:
  - Stimulus: 8×8 at dst (-4,156).
  - Required: only x 0..3, y 156..159 written (16 writes), no fb_addr>38399, done timing unchanged (accept+66).
- Empty command and back-to-back:
  - Stimulus: w=0.
  - Required: no writes, done at accept+1.
  - Stimulus: two 2×2 commands with cmd_valid held high.
  - Required: second accepted the cycle after first done, with correct stride wrap (src_addr base, +1, base+stride, +1).
- Reset mid-run:
  - Stimulus: Reset_n low during row 3 of a 16×16 blit.
  - Required: fb_we=0 immediately, busy=0, cmd_ready=1 after release, no done pulse. A following 1×1 command completes normally.

Source files
------------

// File: rtl/blit_pkg.sv
// blit_pkg: shared constants, state encoding and command record for the framebuffer blitter
package blit_pkg;
  localparam int FB_W = 240;
  localparam int FB_H = 160;
  localparam logic [23:0] KEY = 24'hFF00FF;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} blit_state_t;
  typedef struct packed {
    logic        src_sel;
    logic [18:0] src_base;
    logic [9:0]  src_stride;
    logic [7:0]  w;
    logic [7:0]  h;
    logic [9:0]  dst_x;
    logic [9:0]  dst_y;
    logic        key_en;
  } blit_cmd_t;
endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: walks the command rectangle, producing source reads and clipped destination coordinates
module blit_addr_gen #(
  parameter int FB_W = blit_pkg::FB_W,
  parameter int FB_H = blit_pkg::FB_H
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [18:0]        src_base,
  input  logic [9:0]         src_stride,
  input  logic [7:0]         w,
  input  logic [7:0]         h,
  input  logic [9:0]         dst_x,
  input  logic [9:0]         dst_y,
  output logic [18:0]        src_addr,
  output logic signed [10:0] x,
  output logic signed [10:0] y,
  output logic               in_bounds,
  output logic               last
);
  logic [7:0] col, row;
  logic [18:0] row_off;
  logic wrap;
  assign wrap = col == w - 8'd1;
  assign last = wrap && row == h - 8'd1;
  // row_off accumulates the stride so no multiplier is needed on the source side
  assign src_addr = src_base + row_off + 19'(col);
  assign x = $signed({dst_x[9], dst_x}) + $signed({3'd0, col});
  assign y = $signed({dst_y[9], dst_y}) + $signed({3'd0, row});
  assign in_bounds = !x[10] && x < 11'(FB_W) && !y[10] && y < 11'(FB_H);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      col <= '0;
      row <= '0;
      row_off <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
      row_off <= '0;
    end else if (step) begin
      col <= wrap ? 8'd0 : col + 8'd1;
      row <= wrap ? row + 8'd1 : row;
      row_off <= wrap ? row_off + 19'(src_stride) : row_off;
    end
endmodule

// File: rtl/framebuffer_blitter.sv
// framebuffer_blitter: rectangle copy from a sprite source RAM into the framebuffer, one pixel per clock
module framebuffer_blitter #(
  parameter int          FB_W = blit_pkg::FB_W,
  parameter int          FB_H = blit_pkg::FB_H,
  parameter logic [23:0] KEY  = blit_pkg::KEY
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_src_sel,
  input  logic [18:0] cmd_src_base,
  input  logic [9:0]  cmd_src_stride,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [9:0]  cmd_dst_x,
  input  logic [9:0]  cmd_dst_y,
  input  logic        cmd_key_en,
  output logic        src_sel,
  output logic [18:0] src_addr,
  input  logic [23:0] src_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [23:0] fb_data,
  output logic        busy,
  output logic        done
);
  import blit_pkg::*;
  blit_state_t state;
  blit_cmd_t cmd, cmd_in;
  logic accept, empty, last, in_bounds, pipe_valid, pipe_inb;
  logic signed [10:0] x, y;
  logic [18:0] pipe_addr;
  assign cmd_in = '{cmd_src_sel, cmd_src_base, cmd_src_stride, cmd_w, cmd_h, cmd_dst_x, cmd_dst_y, cmd_key_en};
  assign accept = cmd_valid & cmd_ready;
  assign empty = cmd_w == 8'd0 || cmd_h == 8'd0;
  assign src_sel = cmd.src_sel;
  blit_addr_gen #(.FB_W(FB_W), .FB_H(FB_H)) u_addr (
    .Clk(Clk), .Reset_n(Reset_n), .load(accept), .step(state == RUN),
    .src_base(cmd.src_base), .src_stride(cmd.src_stride), .w(cmd.w), .h(cmd.h),
    .dst_x(cmd.dst_x), .dst_y(cmd.dst_y),
    .src_addr(src_addr), .x(x), .y(y), .in_bounds(in_bounds), .last(last)
  );
  // write stage lines up with the source RAM's one-cycle registered read
  assign fb_we = pipe_valid & pipe_inb & ~(cmd.key_en & (src_data == KEY));
  assign fb_data = pipe_valid ? src_data : '0;
  assign fb_addr = pipe_addr;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      cmd <= '0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_inb <= 1'b0;
      pipe_addr <= '0;
    end else begin
      pipe_valid <= state == RUN;
      pipe_inb <= in_bounds;
      pipe_addr <= {y, 8'd0} - 19'({y, 4'd0}) + 19'(x);
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cmd <= cmd_in;
          state <= empty ? FIN : RUN;
          done <= empty;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
        end
        RUN: if (last) state <= DRAIN;
        DRAIN: begin
          state <= FIN;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
